// File: rtl/rf_access_arbiter_if.sv
// Requester-side bus of the register-file access arbiter: two request ports,
// the shared read-data return path and the clear handshake.
interface rf_access_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) ();
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  clr_start;
    logic                  busy;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr_start,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, busy
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, clr_start,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, busy
    );
endinterface

// File: rtl/rf_access_arbiter.sv
// Round-robin arbiter giving two requesters single-cycle access to one
// register-file port, with a sequential clear that sweeps every entry to zero.
module rf_access_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    rf_access_arbiter_if.slave    bus,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [ADDR_WIDTH-1:0] rf_raddr,
    output logic [DATA_WIDTH-1:0] rf_din,
    input  logic [DATA_WIDTH-1:0] rf_dout
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REG_COUNT - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic                  ptr;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0_q;
    logic                  rvalid1_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // A request loses only when the other side also requests and is favoured.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst && state == IDLE && !bus.clr_start) begin
            if (bus.req0 && (!bus.req1 || !ptr))
                gnt0 = 1'b1;
            else if (bus.req1)
                gnt1 = 1'b1;
        end
    end

    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = clr_cnt;
        rf_din   = '0;
        if (!rst) begin
            if (state == CLEAR) begin
                rf_wen   = 1'b1;
                rf_waddr = clr_cnt;
                rf_din   = '0;
            end else if (gnt0) begin
                rf_wen   = bus.we0;
                rf_waddr = bus.addr0;
                rf_din   = bus.wdata0;
            end else if (gnt1) begin
                rf_wen   = bus.we1;
                rf_waddr = bus.addr1;
                rf_din   = bus.wdata1;
            end
        end
    end

    // With no grant the read port follows the favoured requester.
    always_comb begin
        if (gnt1)
            rf_raddr = bus.addr1;
        else if (gnt0)
            rf_raddr = bus.addr0;
        else if (ptr)
            rf_raddr = bus.addr1;
        else
            rf_raddr = bus.addr0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            ptr       <= 1'b0;
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0 && !bus.we0;
            rvalid1_q <= gnt1 && !bus.we1;
            if ((gnt0 && !bus.we0) || (gnt1 && !bus.we1))
                rdata_q <= rf_dout;
            case (state)
                IDLE: begin
                    if (bus.clr_start) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end else if (gnt0) begin
                        ptr <= 1'b1;
                    end else if (gnt1) begin
                        ptr <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        clr_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt0    = gnt0;
    assign bus.gnt1    = gnt1;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.rdata   = rdata_q;
    assign bus.busy    = (state == CLEAR);

endmodule

// File: doc/rf_access_arbiter.md
RF_ACCESS_ARBITER -- requirements
Module: rf_access_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5, register-file address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, register-file data width.
REQ-003 The block SHALL have parameter REG_COUNT, default 32, number of register-file entries to clear.
REQ-004 The block SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 The block SHALL have ports req0/req1, input, 1, access request from requester 0/1.
REQ-007 The block SHALL have ports we0/we1, input, 1, access type (1 = write, 0 = read).
REQ-008 The block SHALL have ports addr0/addr1, input, ADDR_WIDTH, access address.
REQ-009 The block SHALL have ports wdata0/wdata1, input, DATA_WIDTH, write data.
REQ-010 The block SHALL have ports gnt0/gnt1, output, 1, same-cycle grant (combinational).
REQ-011 The block SHALL have ports rvalid0/rvalid1, output, 1, read data valid for requester 0/1.
REQ-012 The block SHALL have port rdata, output, DATA_WIDTH, registered read data shared by both requesters.
REQ-013 The block SHALL have ports clr_start (input, 1, start full clear) and busy (output, 1, clear in progress).
REQ-014 The block SHALL have ports rf_wen (output, 1), rf_waddr and rf_raddr (output, ADDR_WIDTH), rf_din (output, DATA_WIDTH), and rf_dout (input, DATA_WIDTH), which form the register-file side.

Function
REQ-015 The FSM SHALL have two states, IDLE and CLEAR; the reset state is IDLE.
REQ-016 In IDLE, at most one of gnt0/gnt1 SHALL be high per cycle; a grant requires the matching req and no clr_start in the same cycle.
REQ-017 Arbitration SHALL be round-robin, with a 1-bit priority pointer (reset 0 = requester 0 favoured).
REQ-018 Only the favoured requester requesting SHALL be granted; only the other requesting SHALL be granted.
REQ-019 After any granted access, the pointer SHALL favour the non-granted requester on the next cycle; with no grant, the pointer SHALL hold.
REQ-020 A granted write SHALL drive rf_wen=1, rf_waddr=addr, rf_din=wdata in the grant cycle; the register file updates at that edge.
REQ-021 A granted read SHALL drive rf_raddr=addr in the grant cycle and capture rf_dout into rdata at that edge.
REQ-022 After a granted read, rvalidk SHALL be high for exactly one cycle (latency 1); rdata SHALL hold until the next granted read.
REQ-023 A granted write SHALL NOT assert any rvalid; rf_wen SHALL be 0 whenever no write is granted and the FSM is not in CLEAR.
REQ-024 clr_start in IDLE SHALL move the FSM to CLEAR at the next edge; clr_start takes precedence over same-cycle requests (no grant that cycle).
REQ-025 In CLEAR, the block SHALL drive rf_wen=1, rf_din=0, rf_waddr=clear counter, with the counter advancing 0..REG_COUNT-1, one entry per cycle.
REQ-026 CLEAR SHALL last exactly REG_COUNT cycles; after address REG_COUNT-1 is written, the counter returns to 0 and the FSM returns to IDLE.
REQ-027 busy SHALL be high exactly while the FSM is in CLEAR; gnt0/gnt1 SHALL be 0 in CLEAR.
REQ-028 Requests made during CLEAR SHALL be ignored (requesters hold req until granted); clr_start during CLEAR SHALL be ignored (no restart).
REQ-029 rf_raddr SHALL equal addr of the favoured requester when no grant is active (deterministic, no X).

Reset
REQ-030 Reset SHALL force state=IDLE, clear counter=0, pointer=0, rdata=0, rvalid0=rvalid1=0, busy=0.
REQ-031 Reset asserted mid-CLEAR SHALL abort the clear immediately; entries not yet written are left untouched by the block.
REQ-032 During reset, gnt0, gnt1 and rf_wen SHALL be 0.

Verification
REQ-033 Release reset; req0=1, we0=1, addr0=3, wdata0=0xA5 -> gnt0=1, rf_wen=1, rf_waddr=3, rf_din=0xA5 in the same cycle.
REQ-034 Read the entry back: req1=1, we1=0, addr1=3 -> gnt1 in the same cycle; next cycle rvalid1=1 for one cycle with rdata=0xA5, and rvalid0=0.
REQ-035 Hold req0=req1=1 (reads) for 4 cycles after reset -> grants go 0,1,0,1; rvalid pulses follow one cycle later in the same order.
REQ-036 Pulse clr_start together with req0 -> no grant that cycle; busy=1 for 32 cycles with rf_waddr 0..31 and rf_din=0; afterwards a read of addr 3 returns 0x00.
REQ-037 Assert rst at clear cycle 10 -> busy=0, rf_wen=0 immediately; after release, a read of address 20 returns its pre-clear value.
REQ-038 Pulse clr_start again at clear cycle 5 -> no restart; busy falls after the original 32 cycles.
